awg_reg_bank: RTL and testbench

// - Register bank directly downstream of the SPI slave interface. It consumes the REG_WREN/WADR/WDAT and
//   REG_RDEN/RADR strobes and returns REG_RDAT/REG_RVLD.
// - Holds the AWG control/status map. Length and gain are double-buffered (shadow/active), and the shadow

---
 rtl/awg_reg_pkg.sv | 39 +++
 rtl/awg_reg_commit_fsm.sv | 85 ++++++++
 rtl/awg_reg_bank.sv | 159 +++++++++++++++
 tb/tb_awg_reg_bank.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/awg_reg_pkg.sv
// Shared constants for the AWG register bank: address map, bit indices,
// reset values and the commit FSM state type.
package awg_reg_pkg;

  // Register addresses
  localparam logic [7:0] ADR_VERSION  = 8'h00;
  localparam logic [7:0] ADR_SCRATCH  = 8'h01;
  localparam logic [7:0] ADR_CTRL     = 8'h02;
  localparam logic [7:0] ADR_CMD      = 8'h03;
  localparam logic [7:0] ADR_STATUS   = 8'h04;
  localparam logic [7:0] ADR_LEN_SH0  = 8'h10;
  localparam logic [7:0] ADR_LEN_SH1  = 8'h11;
  localparam logic [7:0] ADR_LEN_SH2  = 8'h12;
  localparam logic [7:0] ADR_LEN_SH3  = 8'h13;
  localparam logic [7:0] ADR_GAIN_SH0 = 8'h14;
  localparam logic [7:0] ADR_GAIN_SH1 = 8'h15;

  // CMD bits
  localparam int unsigned CMD_COMMIT    = 0;
  localparam int unsigned CMD_SOFT_TRIG = 1;

  // STATUS bits
  localparam int unsigned STS_COMMIT_PEND = 0;
  localparam int unsigned STS_BUSY        = 1;
  localparam int unsigned STS_ERR_OVR     = 2;
  localparam int unsigned STS_ERR_TO      = 3;

  // CTRL bits
  localparam int unsigned CTRL_RUN_EN     = 0;
  localparam int unsigned CTRL_LOOP_EN    = 1;
  localparam int unsigned CTRL_OUT_SEL_LO = 2;
  localparam int unsigned CTRL_OUT_SEL_HI = 3;

  // Unity gain in the active/shadow gain registers
  localparam logic [15:0] GAIN_RST = 16'h4000;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOAD} commit_st_t;

endpackage

// File: rtl/awg_reg_commit_fsm.sv
// Commit handshake between the register bank and the AWG core.
// Optional request timeout enabled by defining AWG_COMMIT_TIMEOUT_EN.
module awg_reg_commit_fsm
  import awg_reg_pkg::*;
#(
  parameter int unsigned P_TO_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic commit_wr,
  input  logic ack,
  output logic req,
  output logic load,
  output logic commit_pend,
  output logic ovr_set,
  output logic to_set
);

  commit_st_t state_q, state_d;
  logic       to_hit;
  logic       ovr_d, to_d;
  logic       ovr_q, to_q;

`ifdef AWG_COMMIT_TIMEOUT_EN
  localparam int unsigned CntW = (P_TO_CYCLES > 2) ? $clog2(P_TO_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter runs only while requesting; held at zero elsewhere so entry starts from 0
  always_comb begin
    cnt_d = '0;
    if (state_q == S_REQ) cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign to_hit = (state_q == S_REQ) && (cnt_q == CntW'(P_TO_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Next-state logic; ACK outside S_REQ is ignored
  always_comb begin
    state_d = state_q;
    to_d    = 1'b0;
    ovr_d   = commit_wr && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (commit_wr) state_d = S_REQ;
      S_REQ: begin
        if (ack) begin
          state_d = S_LOAD;
        end else if (to_hit) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and error pulses; pulses are registered, so a STATUS W1C can coincide with a set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign req         = (state_q == S_REQ);
  assign load        = (state_q == S_LOAD);
  assign commit_pend = (state_q != S_IDLE);
  assign ovr_set     = ovr_q;
  assign to_set      = to_q;

endmodule

// File: rtl/awg_reg_bank.sv
// AWG control/status register bank behind the SPI slave. LEN and GAIN are
// double-buffered and committed to the core via a REQ/ACK handshake.
// Optional commit timeout enabled by defining AWG_COMMIT_TIMEOUT_EN.
module awg_reg_bank
  import awg_reg_pkg::*;
#(
  parameter int unsigned P_ADDR_WIDTH = 8,
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter logic [7:0]  P_VERSION    = 8'h10,
  parameter int unsigned P_TO_CYCLES  = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REG_WREN,
  input  logic [P_ADDR_WIDTH-1:0] REG_WADR,
  input  logic [P_DATA_WIDTH-1:0] REG_WDAT,
  input  logic                    REG_RDEN,
  input  logic [P_ADDR_WIDTH-1:0] REG_RADR,
  output logic [P_DATA_WIDTH-1:0] REG_RDAT,
  output logic                    REG_RVLD,
  output logic                    AWG_RUN_EN,
  output logic                    AWG_LOOP_EN,
  output logic [1:0]              AWG_OUT_SEL,
  output logic                    AWG_SOFT_TRIG,
  output logic [31:0]             AWG_LEN,
  output logic [15:0]             AWG_GAIN,
  input  logic                    AWG_BUSY,
  output logic                    CFG_UPD_REQ,
  input  logic                    CFG_UPD_ACK
);

  logic [7:0]  wadr, radr, wdat;
  logic        wr_cmd, wr_sts, commit_wr;
  logic        load, commit_pend, ovr_set, to_set;
  logic [7:0]  scratch_q, status, rd_byte, rdat_q;
  logic [3:0]  ctrl_q;
  logic [31:0] len_sh_q, len_q;
  logic [15:0] gain_sh_q, gain_q;
  logic        trig_q, rvld_q, err_ovr_q, err_to_q, busy_meta_q, busy_sync_q;

  assign wadr      = 8'(REG_WADR);
  assign radr      = 8'(REG_RADR);
  assign wdat      = 8'(REG_WDAT);
  assign wr_cmd    = REG_WREN && (wadr == ADR_CMD);
  assign wr_sts    = REG_WREN && (wadr == ADR_STATUS);
  assign commit_wr = wr_cmd && wdat[CMD_COMMIT];

  awg_reg_commit_fsm #(
    .P_TO_CYCLES (P_TO_CYCLES)
  ) u_commit_fsm (
    .clk         (CLK),
    .rst         (RST),
    .commit_wr   (commit_wr),
    .ack         (CFG_UPD_ACK),
    .req         (CFG_UPD_REQ),
    .load        (load),
    .commit_pend (commit_pend),
    .ovr_set     (ovr_set),
    .to_set      (to_set)
  );

  // Writable registers: scratch, ctrl and the LEN/GAIN shadow bytes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scratch_q <= 8'h00;
      ctrl_q    <= 4'h0;
      len_sh_q  <= 32'd0;
      gain_sh_q <= GAIN_RST;
    end else if (REG_WREN) begin
      case (wadr)
        ADR_SCRATCH:  scratch_q       <= wdat;
        ADR_CTRL:     ctrl_q          <= wdat[3:0];
        ADR_LEN_SH0:  len_sh_q[7:0]   <= wdat;
        ADR_LEN_SH1:  len_sh_q[15:8]  <= wdat;
        ADR_LEN_SH2:  len_sh_q[23:16] <= wdat;
        ADR_LEN_SH3:  len_sh_q[31:24] <= wdat;
        ADR_GAIN_SH0: gain_sh_q[7:0]  <= wdat;
        ADR_GAIN_SH1: gain_sh_q[15:8] <= wdat;
        default: ;
      endcase
    end
  end

  // Active copies load from the shadow values held during the load cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_q  <= 32'd0;
      gain_q <= GAIN_RST;
    end else if (load) begin
      len_q  <= len_sh_q;
      gain_q <= gain_sh_q;
    end
  end

  // Soft trigger pulse, sticky errors (set beats W1C) and busy synchroniser
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trig_q      <= 1'b0;
      err_ovr_q   <= 1'b0;
      err_to_q    <= 1'b0;
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
    end else begin
      trig_q      <= wr_cmd && wdat[CMD_SOFT_TRIG];
      err_ovr_q   <= ovr_set || (err_ovr_q && !(wr_sts && wdat[STS_ERR_OVR]));
      err_to_q    <= to_set || (err_to_q && !(wr_sts && wdat[STS_ERR_TO]));
      busy_meta_q <= AWG_BUSY;
      busy_sync_q <= busy_meta_q;
    end
  end

  // STATUS view
  always_comb begin
    status                  = 8'h00;
    status[STS_COMMIT_PEND] = commit_pend;
    status[STS_BUSY]        = busy_sync_q;
    status[STS_ERR_OVR]     = err_ovr_q;
    status[STS_ERR_TO]      = err_to_q;
  end

  // Read mux over current register values, so same-cycle writes are not visible
  always_comb begin
    rd_byte = 8'h00;
    case (radr)
      ADR_VERSION:  rd_byte = P_VERSION;
      ADR_SCRATCH:  rd_byte = scratch_q;
      ADR_CTRL:     rd_byte = {4'h0, ctrl_q};
      ADR_STATUS:   rd_byte = status;
      ADR_LEN_SH0:  rd_byte = len_sh_q[7:0];
      ADR_LEN_SH1:  rd_byte = len_sh_q[15:8];
      ADR_LEN_SH2:  rd_byte = len_sh_q[23:16];
      ADR_LEN_SH3:  rd_byte = len_sh_q[31:24];
      ADR_GAIN_SH0: rd_byte = gain_sh_q[7:0];
      ADR_GAIN_SH1: rd_byte = gain_sh_q[15:8];
      default:      rd_byte = 8'h00;
    endcase
  end

  // Read data register holds until the next read; valid is a 1-cycle pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdat_q <= 8'h00;
      rvld_q <= 1'b0;
    end else begin
      rvld_q <= REG_RDEN;
      if (REG_RDEN) rdat_q <= rd_byte;
    end
  end

  assign REG_RDAT      = P_DATA_WIDTH'(rdat_q);
  assign REG_RVLD      = rvld_q;
  assign AWG_RUN_EN    = ctrl_q[CTRL_RUN_EN];
  assign AWG_LOOP_EN   = ctrl_q[CTRL_LOOP_EN];
  assign AWG_OUT_SEL   = ctrl_q[CTRL_OUT_SEL_HI:CTRL_OUT_SEL_LO];
  assign AWG_SOFT_TRIG = trig_q;
  assign AWG_LEN       = len_q;
  assign AWG_GAIN      = gain_q;

endmodule

// File: tb/tb_awg_reg_bank.sv
// Scoreboard bench for awg_reg_bank: stimulus queues expected reads and
// expected output snapshots; a negedge monitor pops and compares them.
module tb_awg_reg_bank;

  logic        CLK, RST;
  logic        REG_WREN, REG_RDEN;
  logic [7:0]  REG_WADR, REG_WDAT, REG_RADR, REG_RDAT;
  logic        REG_RVLD;
  logic        AWG_RUN_EN, AWG_LOOP_EN, AWG_SOFT_TRIG;
  logic [1:0]  AWG_OUT_SEL;
  logic [31:0] AWG_LEN;
  logic [15:0] AWG_GAIN;
  logic        AWG_BUSY, CFG_UPD_REQ, CFG_UPD_ACK;

  awg_reg_bank #(
    .P_ADDR_WIDTH (8),
    .P_DATA_WIDTH (8),
    .P_VERSION    (8'h10),
    .P_TO_CYCLES  (16)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .REG_WREN      (REG_WREN),
    .REG_WADR      (REG_WADR),
    .REG_WDAT      (REG_WDAT),
    .REG_RDEN      (REG_RDEN),
    .REG_RADR      (REG_RADR),
    .REG_RDAT      (REG_RDAT),
    .REG_RVLD      (REG_RVLD),
    .AWG_RUN_EN    (AWG_RUN_EN),
    .AWG_LOOP_EN   (AWG_LOOP_EN),
    .AWG_OUT_SEL   (AWG_OUT_SEL),
    .AWG_SOFT_TRIG (AWG_SOFT_TRIG),
    .AWG_LEN       (AWG_LEN),
    .AWG_GAIN      (AWG_GAIN),
    .AWG_BUSY      (AWG_BUSY),
    .CFG_UPD_REQ   (CFG_UPD_REQ),
    .CFG_UPD_ACK   (CFG_UPD_ACK)
  );

  // Output snapshot: {REQ, TRIG, OUT_SEL, LOOP, RUN, GAIN, LEN}
  logic [53:0] port_vec;
  assign port_vec = {CFG_UPD_REQ, AWG_SOFT_TRIG, AWG_OUT_SEL, AWG_LOOP_EN, AWG_RUN_EN,
                     AWG_GAIN, AWG_LEN};

  localparam logic [53:0] M_LEN  = 54'h00_0000_FFFF_FFFF;
  localparam logic [53:0] M_GAIN = 54'h00_FFFF_0000_0000;
  localparam logic [53:0] M_CTRL = 54'h0F_0000_0000_0000;
  localparam logic [53:0] M_TRIG = 54'h10_0000_0000_0000;
  localparam logic [53:0] M_REQ  = 54'h20_0000_0000_0000;
  localparam logic [53:0] M_ALL  = {54{1'b1}};

  typedef struct {
    int unsigned cyc;
    logic [7:0]  exp;
    string       name;
  } rd_item_t;

  typedef struct {
    int unsigned cyc;
    logic [53:0] mask;
    logic [53:0] val;
    string       name;
  } port_item_t;

  rd_item_t    rq[$];
  port_item_t  pq[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic        done = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [53:0] pv(input logic req, input logic trig, input logic [3:0] ctrl,
                                     input logic [15:0] gain, input logic [31:0] len);
    return {req, trig, ctrl, gain, len};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_port(input int unsigned dly, input logic [53:0] mask,
                             input logic [53:0] val, input string name);
    port_item_t p;
    p.cyc  = cyc + dly;
    p.mask = mask;
    p.val  = val & mask;
    p.name = name;
    pq.push_back(p);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    REG_WREN = 1'b1;
    REG_WADR = a;
    REG_WDAT = d;
    step();
    REG_WREN = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    rd_item_t r;
    r.cyc  = cyc + 1;
    r.exp  = exp;
    r.name = name;
    rq.push_back(r);
    REG_RDEN = 1'b1;
    REG_RADR = a;
    step();
    REG_RDEN = 1'b0;
  endtask

  // Monitor: compares due output snapshots and every read-valid against the queues
  always @(negedge CLK) begin
    port_item_t p;
    rd_item_t   r;
    while (pq.size() != 0 && pq[0].cyc <= cyc) begin
      p = pq.pop_front();
      n_chk++;
      if (p.cyc != cyc || (port_vec & p.mask) != p.val) begin
        n_err++;
        $display("FAIL %s: got %h want %h (cycle %0d, due %0d)", p.name, port_vec & p.mask,
                 p.val, cyc, p.cyc);
      end
    end
    if (rq.size() != 0 && rq[0].cyc < cyc) begin
      r = rq.pop_front();
      n_chk++;
      n_err++;
      $display("FAIL %s: got no RVLD want RVLD at cycle %0d", r.name, r.cyc);
    end
    if (REG_RVLD) begin
      n_chk++;
      if (rq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rvld: got RVLD=1 want RVLD=0 at cycle %0d", cyc);
      end else begin
        r = rq.pop_front();
        if (r.cyc != cyc || REG_RDAT != r.exp) begin
          n_err++;
          $display("FAIL %s: got %h at cycle %0d want %h at cycle %0d", r.name, REG_RDAT, cyc,
                   r.exp, r.cyc);
        end
      end
    end
    if (done) begin
      n_chk++;
      if (rq.size() != 0 || pq.size() != 0) begin
        n_err++;
        $display("FAIL drain: got %0d reads %0d snapshots pending want 0 0", rq.size(),
                 pq.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want end within 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; REG_WREN = 1'b0; REG_RDEN = 1'b0; REG_WADR = '0; REG_WDAT = '0;
    REG_RADR = '0; AWG_BUSY = 1'b0; CFG_UPD_ACK = 1'b0;
    repeat (3) step();
    expect_port(0, M_ALL, pv(0, 0, 4'h0, 16'h4000, 32'd0), "reset_outputs");
    step();
    RST = 1'b0;
    step();

    // Reset values and read latency
    rd(8'h00, 8'h10, "rd_version");
    rd(8'h02, 8'h00, "rd_ctrl_reset");
    rd(8'h14, 8'h00, "rd_gain_sh0_reset");
    rd(8'h15, 8'h40, "rd_gain_sh1_reset");
    rd(8'h04, 8'h00, "rd_status_reset");

    // CTRL reaches the outputs one cycle after the write
    expect_port(0, M_CTRL, pv(0, 0, 4'h0, 0, 0), "ctrl_before");
    expect_port(1, M_CTRL, pv(0, 0, 4'hB, 0, 0), "ctrl_applied");
    wr(8'h02, 8'h0B);
    rd(8'h02, 8'h0B, "rd_ctrl");

    // Soft trigger is a single-cycle pulse
    expect_port(0, M_TRIG, pv(0, 0, 0, 0, 0), "trig_before");
    expect_port(1, M_TRIG, pv(0, 1, 0, 0, 0), "trig_pulse");
    expect_port(2, M_TRIG, pv(0, 0, 0, 0, 0), "trig_after");
    wr(8'h03, 8'h02);
    rd(8'h03, 8'h00, "rd_cmd_zero");

    // Same-address read and write returns the old value; unmapped is ignored
    REG_WREN = 1'b1; REG_WADR = 8'h01; REG_WDAT = 8'h5A;
    rd(8'h01, 8'h00, "rd_scratch_prewrite");
    REG_WREN = 1'b0;
    rd(8'h01, 8'h5A, "rd_scratch");
    wr(8'h20, 8'hFF);
    rd(8'h20, 8'h00, "rd_unmapped");

    // Shadow load and first commit
    wr(8'h10, 8'h45); wr(8'h11, 8'h23); wr(8'h12, 8'h01); wr(8'h13, 8'h00);
    wr(8'h14, 8'h00); wr(8'h15, 8'h20);
    rd(8'h10, 8'h45, "rd_len_sh0");
    rd(8'h15, 8'h20, "rd_gain_sh1");
    expect_port(1, M_REQ | M_LEN | M_GAIN, pv(1, 0, 0, 16'h4000, 32'd0), "commit_req");
    wr(8'h03, 8'h01);
    rd(8'h04, 8'h01, "rd_status_pend");
    step(); step();
    expect_port(0, M_REQ | M_LEN, pv(1, 0, 0, 0, 32'd0), "req_held");
    expect_port(1, M_REQ | M_LEN | M_GAIN, pv(0, 0, 0, 16'h4000, 32'd0), "load_cycle");
    expect_port(2, M_REQ | M_LEN | M_GAIN, pv(0, 0, 0, 16'h2000, 32'h0001_2345), "committed");
    CFG_UPD_ACK = 1'b1;
    step();
    CFG_UPD_ACK = 1'b0;
    step();
    rd(8'h04, 8'h00, "rd_status_idle");

    // ACK while idle changes nothing
    expect_port(1, M_REQ | M_LEN, pv(0, 0, 0, 0, 32'h0001_2345), "ack_idle_ignored");
    CFG_UPD_ACK = 1'b1;
    step();
    CFG_UPD_ACK = 1'b0;
    step();

    // Overrun and W1C
    wr(8'h03, 8'h01);
    wr(8'h03, 8'h01);
    step();
    rd(8'h04, 8'h05, "rd_status_ovr");
    wr(8'h04, 8'h04);
    rd(8'h04, 8'h01, "rd_status_w1c");
    wr(8'h03, 8'h01);
    wr(8'h04, 8'h04);
    rd(8'h04, 8'h05, "rd_status_set_wins");
    wr(8'h04, 8'h04);

    // Shadow write during the load cycle lands in the next commit
    CFG_UPD_ACK = 1'b1;
    step();
    CFG_UPD_ACK = 1'b0;
    expect_port(1, M_REQ | M_LEN, pv(0, 0, 0, 0, 32'h0001_2345), "load_excludes_write");
    wr(8'h10, 8'h99);
    rd(8'h10, 8'h99, "rd_len_sh0_new");
    expect_port(3, M_LEN, pv(0, 0, 0, 0, 32'h0001_2399), "second_commit");
    wr(8'h03, 8'h01);
    CFG_UPD_ACK = 1'b1;
    step();
    CFG_UPD_ACK = 1'b0;
    step(); step();
    rd(8'h04, 8'h00, "rd_status_clean");

`ifdef AWG_COMMIT_TIMEOUT_EN
    // Commit with no ACK times out after P_TO_CYCLES cycles of REQ
    expect_port(16, M_REQ, pv(1, 0, 0, 0, 0), "to_req_last");
    expect_port(17, M_REQ, pv(0, 0, 0, 0, 0), "to_req_drop");
    expect_port(18, M_LEN, pv(0, 0, 0, 0, 32'h0001_2399), "to_no_load");
    wr(8'h03, 8'h01);
    repeat (17) step();
    rd(8'h04, 8'h08, "rd_status_err_to");
    wr(8'h04, 8'h08);
    rd(8'h04, 8'h00, "rd_status_to_cleared");
`endif

    // Busy synchroniser, then reset in the middle of a commit
    AWG_BUSY = 1'b1;
    wr(8'h03, 8'h01);
    step(); step();
    rd(8'h04, 8'h03, "rd_status_busy");
    AWG_BUSY = 1'b0;
    repeat (3) step();
    RST = 1'b1;
    expect_port(0, M_ALL, pv(0, 0, 4'h0, 16'h4000, 32'd0), "async_reset");
    step(); step();
    RST = 1'b0;
    step();
    rd(8'h04, 8'h00, "rd_status_after_rst");
    rd(8'h15, 8'h40, "rd_gain_sh1_after_rst");
    rd(8'h02, 8'h00, "rd_ctrl_after_rst");
    step(); step();
    done = 1'b1;
  end

endmodule
